// File: rtl/riscv_alu.sv
// RV32I EX-stage ALU: combinational result/zero (0 cycles) plus a 1-cycle registered copy, no backpressure.
// Define ALU_EXT_CMP_EN to add PASSB (0100), SGE (1100) and SGEU (1101).
module riscv_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       Operation,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic [WIDTH-1:0] ALUResult_q,
  output logic             Zero_q
);

  logic [4:0]       shamt;
  logic             lt_s;
  logic             lt_u;
  logic [WIDTH-1:0] result_d;
  logic             zero_d;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  assign shamt = SrcB[4:0];
  assign lt_s  = $signed(SrcA) < $signed(SrcB);
  assign lt_u  = SrcA < SrcB;

  // Unassigned (and X/Z) codes fall through to the default and produce 0.
  always_comb begin
    result_d = '0;
    case (Operation)
      4'b0000: result_d = SrcA & SrcB;
      4'b0001: result_d = SrcA | SrcB;
      4'b0010: result_d = SrcA + SrcB;
      4'b0011: result_d = SrcA ^ SrcB;
      4'b0110: result_d = SrcA - SrcB;
      4'b0111: result_d = SrcA << shamt;
      4'b1000: result_d = SrcA >> shamt;
      4'b1001: result_d = {{(WIDTH-1){1'b0}}, lt_s};
      4'b1010: result_d = {{(WIDTH-1){1'b0}}, lt_u};
      4'b1011: result_d = $unsigned($signed(SrcA) >>> shamt);
`ifdef ALU_EXT_CMP_EN
      4'b0100: result_d = SrcB;
      4'b1100: result_d = {{(WIDTH-1){1'b0}}, ~lt_s};
      4'b1101: result_d = {{(WIDTH-1){1'b0}}, ~lt_u};
`endif
      default: result_d = '0;
    endcase
  end

  assign zero_d    = (result_d == '0);
  assign ALUResult = result_d;
  assign Zero      = zero_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign ALUResult_q = result_q;
  assign Zero_q      = zero_q;

endmodule

// File: tb/tb_riscv_alu.sv
// Self-checking bench for riscv_alu: directed spec vectors, randomized vectors against an arithmetic model, reset behaviour.
module tb_riscv_alu;

  logic        clk;
  logic        reset;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [3:0]  op;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] alu_result_q;
  logic        zero_q;

  int n_vec;
  int n_err;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  riscv_alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .SrcA       (src_a),
    .SrcB       (src_b),
    .Operation  (op),
    .ALUResult  (alu_result),
    .Zero       (zero),
    .ALUResult_q(alu_result_q),
    .Zero_q     (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic logic [31:0] ref_alu(input logic [3:0] f_op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua;
    longint unsigned ub;
    longint          sa;
    longint          sb;
    longint unsigned m;
    longint unsigned pow;
    longint          q;
    longint unsigned r;
    int              sh;
    ua  = a;
    ub  = b;
    sa  = $signed(a);
    sb  = $signed(b);
    m   = 64'h1_0000_0000;
    sh  = int'(b % 32);
    pow = 64'd1 << sh;
    r   = 0;
    case (f_op)
      OP_AND:  r = ua & ub;
      OP_OR:   r = ua | ub;
      OP_XOR:  r = ua ^ ub;
      OP_ADD:  r = (ua + ub) % m;
      OP_SUB:  r = (ua + m - ub) % m;
      OP_SLL:  r = (ua * pow) % m;
      OP_SRL:  r = ua / pow;
      OP_SRA: begin
        q = sa / longint'(pow);
        if (sa < 0 && q * longint'(pow) != sa) q = q - 1;
        r = longint'(q) % m;
        r = (longint'(q) < 0) ? (m + longint'(q)) % m : r;
      end
      OP_SLT:  r = (sa < sb) ? 1 : 0;
      OP_SLTU: r = (ua < ub) ? 1 : 0;
`ifdef ALU_EXT_CMP_EN
      4'b0100: r = ub;
      4'b1100: r = (sa >= sb) ? 1 : 0;
      4'b1101: r = (ua >= ub) ? 1 : 0;
`endif
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  // Drive one vector, check the combinational outputs, then the registered copy after the next edge.
  task automatic apply(input string tag, input logic [3:0] t_op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit in_rst);
    logic [31:0] exp_q;
    logic        exp_zq;
    op    = t_op;
    src_a = a;
    src_b = b;
    #1;
    check_eq({tag, ".res"}, alu_result, exp);
    check_eq({tag, ".zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
    exp_q  = in_rst ? 32'd0 : exp;
    exp_zq = in_rst ? 1'b0 : (exp == 32'd0);
    @(posedge clk);
    #1;
    check_eq({tag, ".res_q"}, alu_result_q, exp_q);
    check_eq({tag, ".zero_q"}, {31'd0, zero_q}, {31'd0, exp_zq});
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    op    = OP_AND;
    src_a = 32'd0;
    src_b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.res_q", alu_result_q, 32'd0);
    check_eq("rst.zero_q", {31'd0, zero_q}, 32'd0);

    // Combinational path stays live while the registers are held in reset.
    apply("rst_add", OP_ADD, 32'h4, 32'h5, 32'h9, 1'b1);
    apply("rst_or",  OP_OR,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b1);

    @(negedge clk);
    reset = 1'b1;
    apply("add45", OP_ADD, 32'h4, 32'h5, 32'h9, 1'b0);

    apply("and",   OP_AND,  32'h4, 32'h5, 32'h4, 1'b0);
    apply("or",    OP_OR,   32'h4, 32'h5, 32'h5, 1'b0);
    apply("xor",   OP_XOR,  32'h4, 32'h5, 32'h1, 1'b0);
    apply("sub",   OP_SUB,  32'h4, 32'h5, 32'hFFFF_FFFF, 1'b0);
    apply("sub0",  OP_SUB,  32'h5, 32'h5, 32'h0, 1'b0);
    apply("sll",   OP_SLL,  32'h4, 32'hA, 32'h0000_1000, 1'b0);
    apply("srl",   OP_SRL,  32'h4, 32'hA, 32'h0, 1'b0);
    apply("sllhi", OP_SLL,  32'h4, 32'hFFFF_FFE1, 32'h8, 1'b0);
    apply("sll0",  OP_SLL,  32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b0);
    apply("sll31", OP_SLL,  32'h3, 32'h1F, 32'h8000_0000, 1'b0);
    apply("sra31", OP_SRA,  32'h8000_0000, 32'h1F, 32'hFFFF_FFFF, 1'b0);
    apply("slt",   OP_SLT,  32'h113C_2DE4, 32'hFB0B_4877, 32'h0, 1'b0);
    apply("sltu",  OP_SLTU, 32'h113C_2DE4, 32'hFB0B_4877, 32'h1, 1'b0);
    apply("sra",   OP_SRA,  32'hFB0B_4877, 32'hA, 32'hFFFE_C2D2, 1'b0);
    apply("srl2",  OP_SRL,  32'hFB0B_4877, 32'hA, 32'h003E_C2D2, 1'b0);
    apply("slteq", OP_SLT,  32'h8000_0001, 32'h8000_0001, 32'h0, 1'b0);
    apply("sltueq",OP_SLTU, 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b0);
    apply("sltmin",OP_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 1'b0);
    apply("sltumn",OP_SLTU, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 1'b0);
    apply("op1111",4'b1111, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0, 1'b0);
    apply("op0101",4'b0101, 32'h1, 32'h2, 32'h0, 1'b0);
`ifdef ALU_EXT_CMP_EN
    apply("passb", 4'b0100, 32'h7, 32'h1234_5000, 32'h1234_5000, 1'b0);
    apply("sge",   4'b1100, 32'h113C_2DE4, 32'hFB0B_4877, 32'h1, 1'b0);
    apply("sgeu",  4'b1101, 32'h113C_2DE4, 32'hFB0B_4877, 32'h0, 1'b0);
`else
    apply("passb", 4'b0100, 32'h7, 32'h1234_5000, 32'h0, 1'b0);
    apply("sge",   4'b1100, 32'h113C_2DE4, 32'hFB0B_4877, 32'h0, 1'b0);
    apply("sgeu",  4'b1101, 32'h113C_2DE4, 32'hFB0B_4877, 32'h0, 1'b0);
`endif

    for (int i = 0; i < 1500; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = $urandom;
      r_b  = $urandom;
      case ($urandom_range(0, 7))
        0: r_b = r_a;
        1: r_b[4:0] = 5'd0;
        2: r_b[4:0] = 5'd31;
        3: r_a = {1'b1, 31'($urandom_range(0, 3))};
        default: ;
      endcase
      apply("rand", r_op, r_a, r_b, ref_alu(r_op, r_a, r_b), 1'b0);
    end

    // Reset asserted mid-cycle must clear the registers without a clock edge.
    apply("pre_rst", OP_ADD, 32'h4, 32'h5, 32'h9, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    check_eq("midrst.res_q", alu_result_q, 32'd0);
    check_eq("midrst.zero_q", {31'd0, zero_q}, 32'd0);
    check_eq("midrst.res", alu_result, 32'h9);
    @(negedge clk);
    reset = 1'b1;
    apply("post_rst", OP_SUB, 32'h5, 32'h5, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_alu.md
Name: riscv_alu

Overview:
- 32-bit integer ALU for the EX stage of the pipelined RV32I core.
- Combinationally computes `ALUResult` and `Zero` from `SrcA`, `SrcB` and a 4-bit `Operation` code driven by the ALU control decoder.
- A registered copy of both outputs is provided for pipeline-register or forwarding use.
- Clocked by the core clock, with asynchronous active-low reset.

Parameters:
- `WIDTH`, default 32: data width of `SrcA`, `SrcB` and `ALUResult`. Must be 32; other values are unsupported.

Ports:
- `clk`  input  1: core clock, rising-edge active.
- `reset`  input  1: asynchronous, active-low reset (0 = reset asserted).
- `SrcA`  input  32: operand A.
- `SrcB`  input  32: operand B; bits [4:0] give the shift amount for shift operations.
- `Operation`  input  4: operation select.
- `ALUResult`  output  32: combinational result.
- `Zero`  output  1: combinational; 1 when `ALUResult` == 0.
- `ALUResult_q`  output  32: `ALUResult` registered on the rising edge of `clk`.
- `Zero_q`  output  1: `Zero` registered on the rising edge of `clk`.

Behaviour:
- `ALUResult` and `Zero` are purely combinational, with zero-cycle latency.
  - They are valid within the same delta/timestep after any input change.
  - They are independent of `clk` and `reset`, including while `reset` is asserted.
- Operation encoding:
  - 0000 AND: A & B.
  - 0001 OR: A | B.
  - 0010 ADD: A + B, modulo 2^32; no carry or overflow output.
  - 0011 XOR: A ^ B.
  - 0110 SUB: A - B, modulo 2^32 (two's complement).
  - 0111 SLL: A << B[4:0]; zero fill.
  - 1000 SRL: A >> B[4:0]; zero fill.
  - 1001 SLT: 32'd1 if signed(A) < signed(B), else 0.
  - 1010 SLTU: 32'd1 if unsigned(A) < unsigned(B), else 0.
  - 1011 SRA: A >>> B[4:0]; fills with A[31].
- Shift boundary cases:
  - B[31:5] is ignored.
  - A shift by 0 returns A unchanged.
  - A shift by 31 is legal.
- Compare boundary cases:
  - SLT and SLTU return 0 when A == B.
  - SLT(0x80000000, 0x7FFFFFFF) = 1.
  - SLTU(0x80000000, 0x7FFFFFFF) = 0.
- Unassigned codes (0100, 0101, 1100–1111, except those enabled by the optional feature): `ALUResult` = 0 and `Zero` = 1.
- X or Z on `Operation` is treated as an unassigned code; there is no latch inference.
- `Zero` is derived from the final `ALUResult` for every operation, not only SUB.
- Registered outputs:
  - On the rising edge of `clk`, `ALUResult_q` <= `ALUResult` and `Zero_q` <= `Zero`. Latency is 1 cycle.
  - While `reset` = 0, asynchronously and immediately: `ALUResult_q` = 0 and `Zero_q` = 0.
  - A reset asserted between clock edges clears the registers without waiting for `clk`.
  - On release of `reset`, the next rising edge captures the current combinational result.
- There is no handshake and no internal state beyond the two output registers.

Optional Feature:
- Macro: `ALU_EXT_CMP_EN`.
- When defined, three codes are added:
  - 0100 PASSB: `ALUResult` = B, for LUI.
  - 1100 SGE: 32'd1 if signed(A) >= signed(B), else 0.
  - 1101 SGEU: 32'd1 if unsigned(A) >= unsigned(B), else 0.
- When undefined, these codes behave as unassigned: result 0, `Zero` = 1.
- All other encodings are unchanged in both configurations.

Test Plan:
- A=0x4, B=0x5:
  - AND -> 0x4, `Zero`=0.
  - OR -> 0x5.
  - ADD -> 0x9.
  - XOR -> 0x1.
  - SUB -> 0xFFFFFFFF, `Zero`=0.
  - SUB with A=B=0x5 -> 0, `Zero`=1.
- A=0x4, B=0xA:
  - SLL -> 0x00001000.
  - SRL -> 0x0, `Zero`=1.
  - B=0xFFFFFFE1 with SLL -> 0x8, showing only B[4:0] is used.
- A=0x113C2DE4, B=0xFB0B4877:
  - SLT -> 0, `Zero`=1.
  - SLTU -> 1, `Zero`=0.
- A=0xFB0B4877, B=0xA:
  - SRA -> 0xFFFEC2D2.
  - SRL -> 0x003EC2D2.
- Unassigned code 1111 with any operands -> `ALUResult`=0, `Zero`=1.
  - With `ALU_EXT_CMP_EN` defined: 0100 with B=0x12345000 -> 0x12345000.
- Registered path and reset:
  - Hold `reset`=0 -> `ALUResult_q`=0 and `Zero_q`=0 regardless of operands.
  - Release `reset`, apply ADD 4+5 -> `ALUResult_q`=0x9 one rising edge later.
  - Assert `reset` mid-cycle -> `ALUResult_q` clears immediately, without a clock edge.
